// File: rtl/q7_shiftaddmul_solution2_pkg.sv
// Shared definitions for the shift-and-add multiplier: default operand width,
// controller state encoding and iteration-counter sizing.
package q7_shiftaddmul_solution2_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The iteration counter must be able to hold the value n itself.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/q7_shiftaddmul_solution2_shiftadd_datapath.sv
// Shift-and-add datapath: A/Q/B/C registers, the (n+1)-bit adder, the
// right shifter and the registered product output.
module shiftadd_datapath
    import q7_shiftaddmul_solution2_pkg::*;
#(
    parameter int n = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic           last,
    input  logic [n-1:0]   b_in,
    input  logic [n-1:0]   q_in,
    output logic [2*n-1:0] a_out
);

    logic [n-1:0]   a;
    logic [n-1:0]   q;
    logic [n-1:0]   b;
    logic           c;
    logic [n:0]     sum;
    logic [n-1:0]   a_shift;
    logic [n-1:0]   q_shift;

    // Add B into {C,A} when the current multiplier bit is set, then shift
    // {C,A,Q} right by one; the carry lands in the top bit of A.
    always_comb begin
        sum     = {c, a} + (q[0] ? {1'b0, b} : {(n+1){1'b0}});
        a_shift = sum[n:1];
        q_shift = {sum[0], q[n-1:1]};
    end

    // Operand capture on launch, one add/shift step per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            a <= '0;
            q <= '0;
            b <= '0;
            c <= 1'b0;
        end else if (load) begin
            a <= '0;
            q <= q_in;
            b <= b_in;
            c <= 1'b0;
        end else if (step) begin
            a <= a_shift;
            q <= q_shift;
            c <= 1'b0;
        end
    end

    // Publish the post-shift {A,Q} only on the final iteration so a_out
    // keeps the previous product while a new one is being computed.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_out <= '0;
        end else if (last) begin
            a_out <= {a_shift, q_shift};
        end
    end

endmodule

// File: rtl/q7_shiftaddmul_solution2.sv
// Sequential unsigned n x n multiplier. A start pulse in IDLE or DONE loads
// the operands; n iterations later the 2n-bit product is on a_out and stop
// rises. Starts arriving during RUN are ignored.
module q7_shiftaddmul_solution2
    import q7_shiftaddmul_solution2_pkg::*;
#(
    parameter int n = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [n-1:0]   b_in,
    input  logic [n-1:0]   q_in,
    output logic           stop,
    output logic [2*n-1:0] a_out
);

    localparam int CW = count_width(n);
    localparam logic [CW-1:0] COUNT_INIT = CW'(n);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic          load;
    logic          step;
    logic          last;

    // Next-state and datapath strobes; launch is accepted only when idle
    // or holding a finished result.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == COUNT_ONE) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, iteration counter and done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            stop  <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                count <= COUNT_INIT;
                stop  <= 1'b0;
            end else if (step) begin
                count <= count - COUNT_ONE;
                if (last) begin
                    stop <= 1'b1;
                end
            end
        end
    end

    shiftadd_datapath #(
        .n(n)
    ) u_datapath (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .last  (last),
        .b_in  (b_in),
        .q_in  (q_in),
        .a_out (a_out)
    );

endmodule

// File: tb/tb_q7_shiftaddmul_solution2.sv
// Self-checking bench for the shift-and-add multiplier. The reference is the
// plain product b*q with a fixed latency of one load edge plus 8 iterations.
module tb_q7_shiftaddmul_solution2;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  b_in;
    logic [7:0]  q_in;
    logic        stop;
    logic [15:0] a_out;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] last_res = 16'h0000;

    q7_shiftaddmul_solution2 #(.n(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .b_in  (b_in),
        .q_in  (q_in),
        .stop  (stop),
        .a_out (a_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Runs one operation from a negedge. poke_at: iteration edge on which a
    // stray start is driven (0 = none). abort_at: iteration edge with reset.
    task automatic do_op(input logic [7:0] b, input logic [7:0] q,
                         input int poke_at, input int abort_at);
        logic [15:0] expv;
        expv  = 16'(b) * 16'(q);
        start = 1'b1;
        b_in  = b;
        q_in  = q;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        b_in  = 8'($urandom);
        q_in  = 8'($urandom);
        check("launch_stop", 32'(stop), 32'd0);
        check("launch_hold", 32'(a_out), 32'(last_res));
        for (int i = 1; i <= 8; i++) begin
            if (i == poke_at) begin
                start = 1'b1;
                b_in  = 8'($urandom);
                q_in  = 8'($urandom);
            end
            if (i == abort_at) reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (i == abort_at) begin
                reset = 1'b0;
                last_res = 16'h0000;
                check("abort_stop", 32'(stop), 32'd0);
                check("abort_aout", 32'(a_out), 32'd0);
                return;
            end
            if (i < 8) begin
                check("run_stop", 32'(stop), 32'd0);
                check("run_hold", 32'(a_out), 32'(last_res));
            end
        end
        check("done_stop", 32'(stop), 32'd1);
        check("done_prod", 32'(a_out), 32'(expv));
        last_res = expv;
    endtask

    task automatic hold_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            b_in = 8'($urandom);
            q_in = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_stop", 32'(stop), 32'd1);
            check("hold_prod", 32'(a_out), 32'(last_res));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        b_in  = 8'h00;
        q_in  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stop", 32'(stop), 32'd0);
        check("reset_aout", 32'(a_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op(8'h0F, 8'h0E, 0, 0);
        check("basic_value", 32'(a_out), 32'h00D2);
        hold_check(3);
        do_op(8'hFF, 8'hFF, 0, 0);
        check("carry_value", 32'(a_out), 32'hFE01);
        hold_check(1);
        do_op(8'h00, 8'hA5, 0, 0);
        hold_check(1);
        do_op(8'h37, 8'h00, 0, 0);
        hold_check(1);
        do_op(8'h5A, 8'hC3, 3, 0);
        hold_check(1);
        do_op(8'h77, 8'h99, 0, 4);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_stop", 32'(stop), 32'd0);
            check("idle_aout", 32'(a_out), 32'd0);
        end
        do_op(8'h12, 8'h34, 0, 0);
        check("post_abort", 32'(a_out), 32'h03A8);
        do_op(8'h80, 8'h02, 0, 0);
        check("b2b_value", 32'(a_out), 32'h0100);

        for (int k = 0; k < 40; k++) begin
            do_op(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0, 0);
            if ($urandom_range(0, 1) == 1) hold_check(int'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
